// File: rtl/adder_entry_sequencer_if.sv
// ============================================================================
// adder_entry_sequencer_if : board-side bundle (keys, switches, display feeds)
// Rev 1.0
// ============================================================================
`default_nettype none

interface adder_entry_sequencer_if #(
  parameter int W = 8
);
  logic         key_next;
  logic         key_clr;
  logic [W-1:0] sw;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] sum;
  logic         ovf;
  logic [1:0]   state;
  logic         done;
  logic         blink;

  modport master (
    output key_next, key_clr, sw,
    input  op_a, op_b, sum, ovf, state, done, blink
  );

  modport slave (
    input  key_next, key_clr, sw,
    output op_a, op_b, sum, ovf, state, done, blink
  );
endinterface

`default_nettype wire

// File: rtl/adder_entry_sequencer.sv
// ============================================================================
// adder_entry_sequencer : key-driven operand entry and bit-serial W-bit adder
// Rev 1.0
// ============================================================================
`default_nettype none

module adder_entry_sequencer #(
  parameter int W         = 8,
  parameter int BLINK_DIV = 24
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  adder_entry_sequencer_if.slave bus
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    ST_ENTER_A = 2'd0,
    ST_ENTER_B = 2'd1,
    ST_ADD     = 2'd2,
    ST_SHOW    = 2'd3
  } state_t;

  state_t               state_q;
  logic [W-1:0]         op_a_q;
  logic [W-1:0]         op_b_q;
  logic [W-1:0]         sum_q;
  logic                 ovf_q;
  logic                 done_q;
  logic [IW-1:0]        idx_q;
  logic                 carry_q;
  logic [BLINK_DIV-1:0] cnt_q;

  // Keys are active-low; sync chain idles at 1 so a press is a 1->0 edge.
  logic next_s1_q, next_s2_q, next_prev_q;
  logic clr_s1_q,  clr_s2_q,  clr_prev_q;

  logic w_next_evt;
  logic w_clr_evt;
  logic w_a_bit;
  logic w_b_bit;
  logic w_sum_bit;
  logic w_carry;
  logic w_last_bit;

  assign w_next_evt = next_prev_q & ~next_s2_q;
  assign w_clr_evt  = clr_prev_q  & ~clr_s2_q;

  assign w_a_bit    = op_a_q[idx_q];
  assign w_b_bit    = op_b_q[idx_q];
  assign w_sum_bit  = w_a_bit ^ w_b_bit ^ carry_q;
  assign w_carry    = (w_a_bit & w_b_bit) | (w_a_bit & carry_q) | (w_b_bit & carry_q);
  assign w_last_bit = (idx_q == IW'(W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ENTER_A;
      op_a_q      <= '0;
      op_b_q      <= '0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      next_s1_q   <= 1'b1;
      next_s2_q   <= 1'b1;
      next_prev_q <= 1'b1;
      clr_s1_q    <= 1'b1;
      clr_s2_q    <= 1'b1;
      clr_prev_q  <= 1'b1;
    end else begin
      next_s1_q   <= bus.key_next;
      next_s2_q   <= next_s1_q;
      next_prev_q <= next_s2_q;
      clr_s1_q    <= bus.key_clr;
      clr_s2_q    <= clr_s1_q;
      clr_prev_q  <= clr_s2_q;
      cnt_q       <= cnt_q + 1'b1;
      done_q      <= 1'b0;

      if (w_clr_evt) begin
        state_q <= ST_ENTER_A;
        op_a_q  <= '0;
        op_b_q  <= '0;
        sum_q   <= '0;
        ovf_q   <= 1'b0;
        idx_q   <= '0;
        carry_q <= 1'b0;
      end else begin
        case (state_q)
          ST_ENTER_A: begin
            op_a_q <= bus.sw;
            if (w_next_evt) state_q <= ST_ENTER_B;
          end
          ST_ENTER_B: begin
            op_b_q <= bus.sw;
            if (w_next_evt) begin
              state_q <= ST_ADD;
              idx_q   <= '0;
              carry_q <= 1'b0;
              sum_q   <= '0;
            end
          end
          ST_ADD: begin
            sum_q[idx_q] <= w_sum_bit;
            carry_q      <= w_carry;
            idx_q        <= idx_q + 1'b1;
            if (w_last_bit) begin
              ovf_q   <= w_carry;
              done_q  <= 1'b1;
              state_q <= ST_SHOW;
            end
          end
          ST_SHOW: begin
            if (w_next_evt) state_q <= ST_ENTER_A;
          end
          default: state_q <= ST_ENTER_A;
        endcase
      end
    end
  end

  assign bus.op_a  = op_a_q;
  assign bus.op_b  = op_b_q;
  assign bus.sum   = sum_q;
  assign bus.ovf   = ovf_q;
  assign bus.state = state_q;
  assign bus.done  = done_q;
  // Both entry states have encoding bit 1 clear.
  assign bus.blink = cnt_q[BLINK_DIV-1] & ~state_q[1];

endmodule

`default_nettype wire
